rf_access_arbiter: RTL and testbench



---
 rtl/rf_access_arbiter.sv | 254 +++++++++++++++++++++++++
 tb/tb_rf_access_arbiter.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_access_arbiter.sv
// Two-requester round-robin arbiter in front of a single register-file software port.
// One access is outstanding at a time. A watchdog aborts accesses the RF never completes
// and reports them to the requester as an invalid address. Every output is registered.
module rf_access_arbiter #(
    parameter int unsigned ADDR_HI    = 5,
    parameter int unsigned ADDR_LO    = 3,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned TIMEOUT    = 16,
    localparam int unsigned AW        = ADDR_HI - ADDR_LO + 1
) (
    input  logic                  clk,
    input  logic                  res_n,

    input  logic [AW-1:0]         m0_address,
    input  logic                  m0_read_en,
    input  logic                  m0_write_en,
    input  logic [DATA_WIDTH-1:0] m0_write_data,
    output logic [DATA_WIDTH-1:0] m0_read_data,
    output logic                  m0_invalid_address,
    output logic                  m0_access_complete,

    input  logic [AW-1:0]         m1_address,
    input  logic                  m1_read_en,
    input  logic                  m1_write_en,
    input  logic [DATA_WIDTH-1:0] m1_write_data,
    output logic [DATA_WIDTH-1:0] m1_read_data,
    output logic                  m1_invalid_address,
    output logic                  m1_access_complete,

    output logic [AW-1:0]         rf_address,
    output logic                  rf_read_en,
    output logic                  rf_write_en,
    output logic [DATA_WIDTH-1:0] rf_write_data,
    input  logic [DATA_WIDTH-1:0] rf_read_data,
    input  logic                  rf_invalid_address,
    input  logic                  rf_access_complete,

    output logic [1:0]            grant,
    output logic [7:0]            timeout_count
);

    // Last WAIT cycle index before the watchdog fires
    localparam logic [7:0] TimerLast = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StResp
    } state_e;

    state_e state_q, state_d;

    logic [1:0]            grant_q, grant_d;
    logic                  last_m1_q, last_m1_d;
    logic                  is_write_q, is_write_d;
    logic [7:0]            timer_q, timer_d;
    logic [7:0]            tcount_q, tcount_d;
    logic [AW-1:0]         rf_address_q, rf_address_d;
    logic [DATA_WIDTH-1:0] rf_write_data_q, rf_write_data_d;
    logic                  rf_read_en_q, rf_read_en_d;
    logic                  rf_write_en_q, rf_write_en_d;
    logic [DATA_WIDTH-1:0] m0_read_data_q, m0_read_data_d;
    logic                  m0_invalid_q, m0_invalid_d;
    logic                  m0_complete_q, m0_complete_d;
    logic [DATA_WIDTH-1:0] m1_read_data_q, m1_read_data_d;
    logic                  m1_invalid_q, m1_invalid_d;
    logic                  m1_complete_q, m1_complete_d;

    logic                  req0, req1, any_req, pick_m1;
    logic                  win_rd, win_wr, proto_err;
    logic [AW-1:0]         win_addr;
    logic [DATA_WIDTH-1:0] win_wdata;
    logic                  timer_expired;

    logic                  resp_fire, resp_m1, resp_inv;
    logic [DATA_WIDTH-1:0] resp_data;

    // Request decode and round-robin winner selection (only acted on in IDLE)
    always_comb begin
        req0      = m0_read_en | m0_write_en;
        req1      = m1_read_en | m1_write_en;
        any_req   = req0 | req1;
        // m1 wins when alone, or under contention when m0 was served last
        pick_m1   = req1 & (~req0 | ~last_m1_q);
        win_rd    = pick_m1 ? m1_read_en    : m0_read_en;
        win_wr    = pick_m1 ? m1_write_en   : m0_write_en;
        win_addr  = pick_m1 ? m1_address    : m0_address;
        win_wdata = pick_m1 ? m1_write_data : m0_write_data;
        proto_err = win_rd & win_wr;
        timer_expired = (timer_q == TimerLast);
    end

    // State register
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (any_req) begin
                    state_d = proto_err ? StResp : StIssue;
                end
            end
            StIssue: state_d = StWait;
            StWait: begin
                if (rf_access_complete || timer_expired) begin
                    state_d = StResp;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Next values of the datapath and registered outputs
    always_comb begin
        grant_d         = grant_q;
        last_m1_d       = last_m1_q;
        is_write_d      = is_write_q;
        timer_d         = timer_q;
        tcount_d        = tcount_q;
        rf_address_d    = rf_address_q;
        rf_write_data_d = rf_write_data_q;
        rf_read_en_d    = 1'b0;
        rf_write_en_d   = 1'b0;
        m0_read_data_d  = '0;
        m0_invalid_d    = 1'b0;
        m0_complete_d   = 1'b0;
        m1_read_data_d  = '0;
        m1_invalid_d    = 1'b0;
        m1_complete_d   = 1'b0;
        resp_fire       = 1'b0;
        resp_m1         = grant_q[1];
        resp_inv        = 1'b0;
        resp_data       = '0;

        case (state_q)
            StIdle: begin
                if (any_req) begin
                    grant_d = pick_m1 ? 2'b10 : 2'b01;
                    resp_m1 = pick_m1;
                    if (proto_err) begin
                        // Both strobes at once: never touch the RF, report invalid
                        resp_fire = 1'b1;
                        resp_inv  = 1'b1;
                    end else begin
                        rf_address_d    = win_addr;
                        rf_write_data_d = win_wdata;
                        is_write_d      = win_wr;
                        rf_read_en_d    = win_rd;
                        rf_write_en_d   = win_wr;
                    end
                end
            end
            StIssue: begin
                timer_d = '0;
            end
            StWait: begin
                timer_d = timer_q + 8'd1;
                // Completion takes priority over a simultaneous timeout
                if (rf_access_complete) begin
                    resp_fire = 1'b1;
                    resp_data = is_write_q ? '0 : rf_read_data;
                    resp_inv  = rf_invalid_address;
                end else if (timer_expired) begin
                    resp_fire = 1'b1;
                    resp_inv  = 1'b1;
                    if (tcount_q != 8'hFF) begin
                        tcount_d = tcount_q + 8'd1;
                    end
                end
            end
            StResp: begin
                last_m1_d = grant_q[1];
                grant_d   = '0;
            end
            default: begin
                grant_d = '0;
            end
        endcase

        // Route the response to the owner only; the other side stays at zero
        if (resp_fire) begin
            if (resp_m1) begin
                m1_complete_d  = 1'b1;
                m1_invalid_d   = resp_inv;
                m1_read_data_d = resp_data;
            end else begin
                m0_complete_d  = 1'b1;
                m0_invalid_d   = resp_inv;
                m0_read_data_d = resp_data;
            end
        end
    end

    // Datapath and output registers; reset abandons any access in flight
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            grant_q         <= '0;
            last_m1_q       <= 1'b1;
            is_write_q      <= 1'b0;
            timer_q         <= '0;
            tcount_q        <= '0;
            rf_address_q    <= '0;
            rf_write_data_q <= '0;
            rf_read_en_q    <= 1'b0;
            rf_write_en_q   <= 1'b0;
            m0_read_data_q  <= '0;
            m0_invalid_q    <= 1'b0;
            m0_complete_q   <= 1'b0;
            m1_read_data_q  <= '0;
            m1_invalid_q    <= 1'b0;
            m1_complete_q   <= 1'b0;
        end else begin
            grant_q         <= grant_d;
            last_m1_q       <= last_m1_d;
            is_write_q      <= is_write_d;
            timer_q         <= timer_d;
            tcount_q        <= tcount_d;
            rf_address_q    <= rf_address_d;
            rf_write_data_q <= rf_write_data_d;
            rf_read_en_q    <= rf_read_en_d;
            rf_write_en_q   <= rf_write_en_d;
            m0_read_data_q  <= m0_read_data_d;
            m0_invalid_q    <= m0_invalid_d;
            m0_complete_q   <= m0_complete_d;
            m1_read_data_q  <= m1_read_data_d;
            m1_invalid_q    <= m1_invalid_d;
            m1_complete_q   <= m1_complete_d;
        end
    end

    assign grant              = grant_q;
    assign timeout_count      = tcount_q;
    assign rf_address         = rf_address_q;
    assign rf_write_data      = rf_write_data_q;
    assign rf_read_en         = rf_read_en_q;
    assign rf_write_en        = rf_write_en_q;
    assign m0_read_data       = m0_read_data_q;
    assign m0_invalid_address = m0_invalid_q;
    assign m0_access_complete = m0_complete_q;
    assign m1_read_data       = m1_read_data_q;
    assign m1_invalid_address = m1_invalid_q;
    assign m1_access_complete = m1_complete_q;

endmodule

// File: tb/tb_rf_access_arbiter.sv
// Directed bench for rf_access_arbiter with a small behavioural RF responder.
module tb_rf_access_arbiter;

    localparam int unsigned AW = 3;
    localparam int unsigned DW = 64;
    localparam int unsigned TO = 16;

    logic          clk, res_n;
    logic [AW-1:0] m0_address, m1_address, rf_address;
    logic          m0_read_en, m0_write_en, m1_read_en, m1_write_en;
    logic [DW-1:0] m0_write_data, m1_write_data, m0_read_data, m1_read_data;
    logic          m0_invalid_address, m0_access_complete;
    logic          m1_invalid_address, m1_access_complete;
    logic          rf_read_en, rf_write_en;
    logic [DW-1:0] rf_write_data, rf_read_data;
    logic          rf_invalid_address, rf_access_complete;
    logic [1:0]    grant;
    logic [7:0]    timeout_count;

    int   n_vec = 0;
    int   n_err = 0;
    int   strobe_cnt = 0;
    logic outstanding;
    logic rf_hang;

    rf_access_arbiter #(
        .ADDR_HI   (5),
        .ADDR_LO   (3),
        .DATA_WIDTH(DW),
        .TIMEOUT   (TO)
    ) dut (
        .clk               (clk),
        .res_n             (res_n),
        .m0_address        (m0_address),
        .m0_read_en        (m0_read_en),
        .m0_write_en       (m0_write_en),
        .m0_write_data     (m0_write_data),
        .m0_read_data      (m0_read_data),
        .m0_invalid_address(m0_invalid_address),
        .m0_access_complete(m0_access_complete),
        .m1_address        (m1_address),
        .m1_read_en        (m1_read_en),
        .m1_write_en       (m1_write_en),
        .m1_write_data     (m1_write_data),
        .m1_read_data      (m1_read_data),
        .m1_invalid_address(m1_invalid_address),
        .m1_access_complete(m1_access_complete),
        .rf_address        (rf_address),
        .rf_read_en        (rf_read_en),
        .rf_write_en       (rf_write_en),
        .rf_write_data     (rf_write_data),
        .rf_read_data      (rf_read_data),
        .rf_invalid_address(rf_invalid_address),
        .rf_access_complete(rf_access_complete),
        .grant             (grant),
        .timeout_count     (timeout_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        case (a)
            3'd0:    return 64'h0000_0000_0012_ABCD;
            3'd2:    return 64'h0000_2222_BEEF_0002;
            default: return 64'h0;
        endcase
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for either completion pulse; lat counts cycles from the request cycle
    task automatic wait_done(input string tag, input int max_cyc, output int which,
                             output int lat);
        which = -1;
        lat   = 0;
        for (int k = 0; k < max_cyc; k++) begin
            tick();
            lat++;
            if (m0_access_complete || m1_access_complete) begin
                which = m0_access_complete ? 0 : 1;
                break;
            end
        end
        if (which < 0) check_eq({tag, "_bound"}, 0, 1);
    endtask

    // RF responder: completes one cycle after the strobe unless rf_hang is set
    initial begin
        logic          pend;
        logic          pend_wr;
        logic [AW-1:0] pend_addr;
        pend = 1'b0;
        pend_wr = 1'b0;
        pend_addr = '0;
        outstanding = 1'b0;
        rf_access_complete = 1'b0;
        rf_read_data = '0;
        rf_invalid_address = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            rf_access_complete = 1'b0;
            rf_read_data = '0;
            rf_invalid_address = 1'b0;
            if (!res_n) begin
                pend = 1'b0;
                outstanding = 1'b0;
            end else begin
                if (m0_access_complete || m1_access_complete) outstanding = 1'b0;
                if (pend) begin
                    rf_access_complete = 1'b1;
                    if (pend_wr) rf_read_data = 64'hDEAD_BEEF_DEAD_BEEF;
                    else if (pend_addr == 3'd3) rf_invalid_address = 1'b1;
                    else rf_read_data = mem_word(pend_addr);
                    pend = 1'b0;
                end
                if (rf_read_en || rf_write_en) begin
                    check_eq("no_overlap", outstanding, 0);
                    outstanding = 1'b1;
                    strobe_cnt++;
                    pend = !rf_hang;
                    pend_wr = rf_write_en;
                    pend_addr = rf_address;
                end
            end
        end
    end

    initial begin
        int which, lat, s0;
        res_n = 1'b0;
        rf_hang = 1'b0;
        m0_address = '0; m0_read_en = 0; m0_write_en = 0; m0_write_data = '0;
        m1_address = '0; m1_read_en = 0; m1_write_en = 0; m1_write_data = '0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_grant", grant, 0);
        check_eq("rst_tcount", timeout_count, 0);
        check_eq("rst_m0_cmpl", m0_access_complete, 0);
        check_eq("rst_rf_rd", rf_read_en, 0);
        res_n = 1'b1;
        tick();

        // Single write from m0
        s0 = strobe_cnt;
        m0_address = 3'd1; m0_write_data = 64'h555AAA555AAA555A; m0_write_en = 1'b1;
        tick();
        check_eq("wr_grant", grant, 2'b01);
        check_eq("wr_strobe", rf_write_en, 1);
        check_eq("wr_rd_strobe", rf_read_en, 0);
        check_eq("wr_addr", rf_address, 1);
        check_eq("wr_data", rf_write_data, 64'h555AAA555AAA555A);
        tick();
        check_eq("wr_strobe_off", rf_write_en, 0);
        check_eq("wr_early_cmpl", m0_access_complete, 0);
        tick();
        check_eq("wr_cmpl", m0_access_complete, 1);
        check_eq("wr_inv", m0_invalid_address, 0);
        check_eq("wr_rdata_zero", m0_read_data, 0);
        check_eq("wr_m1_cmpl", m1_access_complete, 0);
        check_eq("wr_m1_data", m1_read_data, 0);
        check_eq("wr_one_strobe", strobe_cnt - s0, 1);
        m0_write_en = 1'b0;
        tick();
        check_eq("wr_cmpl_pulse", m0_access_complete, 0);
        check_eq("wr_grant_idle", grant, 0);

        // m1 read of an address the RF rejects
        m1_address = 3'd3; m1_read_en = 1'b1;
        wait_done("inv", 10, which, lat);
        check_eq("inv_who", which, 1);
        check_eq("inv_lat", lat, 3);
        check_eq("inv_flag", m1_invalid_address, 1);
        check_eq("inv_data", m1_read_data, 0);
        check_eq("inv_m0_cmpl", m0_access_complete, 0);
        m1_read_en = 1'b0;
        tick();

        // Continuous contention: m1 was served last, so m0 leads
        m0_address = 3'd0; m0_read_en = 1'b1;
        m1_address = 3'd2; m1_read_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_done("rr", 10, which, lat);
            check_eq("rr_order", which, i % 2);
            check_eq("rr_lat", lat, (i == 0) ? 3 : 4);
            if (i % 2 == 0) check_eq("rr_m0_data", m0_read_data, 64'h12ABCD);
            else check_eq("rr_m1_data", m1_read_data, 64'h0000_2222_BEEF_0002);
        end
        m0_read_en = 1'b0; m1_read_en = 1'b0;
        tick();

        // RF never completes: watchdog abort
        rf_hang = 1'b1;
        m0_address = 3'd0; m0_read_en = 1'b1;
        wait_done("to", 40, which, lat);
        check_eq("to_who", which, 0);
        check_eq("to_lat", lat, TO + 2);
        check_eq("to_inv", m0_invalid_address, 1);
        check_eq("to_data", m0_read_data, 0);
        check_eq("to_count", timeout_count, 1);
        m0_read_en = 1'b0;
        rf_hang = 1'b0;
        tick();
        m1_address = 3'd2; m1_read_en = 1'b1;
        wait_done("after_to", 10, which, lat);
        check_eq("after_to_who", which, 1);
        check_eq("after_to_lat", lat, 3);
        check_eq("after_to_data", m1_read_data, 64'h0000_2222_BEEF_0002);
        check_eq("after_to_inv", m1_invalid_address, 0);
        check_eq("after_to_count", timeout_count, 1);
        m1_read_en = 1'b0;
        tick();

        // Read and write together: protocol error, no RF access
        s0 = strobe_cnt;
        m0_address = 3'd2; m0_read_en = 1'b1; m0_write_en = 1'b1;
        tick();
        check_eq("perr_cmpl", m0_access_complete, 1);
        check_eq("perr_inv", m0_invalid_address, 1);
        check_eq("perr_data", m0_read_data, 0);
        check_eq("perr_grant", grant, 2'b01);
        check_eq("perr_rd_strobe", rf_read_en, 0);
        check_eq("perr_wr_strobe", rf_write_en, 0);
        m0_read_en = 1'b0; m0_write_en = 1'b0;
        tick();
        check_eq("perr_cmpl_pulse", m0_access_complete, 0);
        tick();
        check_eq("perr_no_strobe", strobe_cnt - s0, 0);

        // Reset while waiting on the RF
        rf_hang = 1'b1;
        m1_address = 3'd2; m1_read_en = 1'b1;
        tick();
        tick();
        check_eq("rstw_grant_pre", grant, 2'b10);
        #2;
        res_n = 1'b0;
        #1;
        check_eq("rstw_grant", grant, 0);
        check_eq("rstw_addr", rf_address, 0);
        check_eq("rstw_tcount", timeout_count, 0);
        check_eq("rstw_m1_cmpl", m1_access_complete, 0);
        for (int k = 0; k < 2; k++) begin
            tick();
            check_eq("rstw_no_cmpl", m1_access_complete | m0_access_complete, 0);
        end
        rf_hang = 1'b0;
        m0_address = 3'd0; m0_read_en = 1'b1;
        res_n = 1'b1;
        wait_done("rstw_first", 10, which, lat);
        check_eq("rstw_first_who", which, 0);
        check_eq("rstw_first_data", m0_read_data, 64'h12ABCD);
        m0_read_en = 1'b0; m1_read_en = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
